mul_issue_ctrl: RTL



---
 rtl/mul_pkg.sv | 18 +
 rtl/sign_mag_conv.sv | 19 +
 rtl/mul_issue_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared types and constants for the multiplier issue controller.
package mul_pkg;

    localparam int unsigned MUL_W  = 32;
    localparam int unsigned PROD_W = 64;

    localparam int unsigned DEF_SETTLE_CYCLES  = 2;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 40;
    localparam int unsigned DEF_CNT_W          = 6;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StResp  = 2'd3
    } state_e;

endpackage

// File: rtl/sign_mag_conv.sv
// Combinational absolute value: negates the operand when sign_en is set and its MSB is 1.
// 0x80000000 maps to itself, which is the correct magnitude when read as unsigned.
module sign_mag_conv
    import mul_pkg::*;
(
    input  logic [MUL_W-1:0] din,
    input  logic             sign_en,
    output logic [MUL_W-1:0] mag
);

    // Two's-complement negate only for negative signed inputs
    always_comb begin
        mag = din;
        if (sign_en && din[MUL_W-1]) begin
            mag = ~din + MUL_W'(1);
        end
    end

endmodule

// File: rtl/mul_issue_ctrl.sv
// Request/response front-end for the iterative 32x32 multiplier. Registers operand
// magnitudes, lets the multiplier's change detect settle, waits for Done (with a
// watchdog) and returns the sign-corrected 64-bit product.
module mul_issue_ctrl
    import mul_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned CNT_W          = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [MUL_W-1:0] req_a,
    input  logic [MUL_W-1:0] req_b,
    input  logic             req_signed,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [MUL_W-1:0] rsp_hi,
    output logic [MUL_W-1:0] rsp_lo,
    output logic             rsp_timeout,
    output logic [MUL_W-1:0] mul_a,
    output logic [MUL_W-1:0] mul_b,
    input  logic             mul_done,
    input  logic [MUL_W-1:0] mul_res_high,
    input  logic [MUL_W-1:0] mul_res_low,
    output logic             busy
);

    localparam logic [CNT_W-1:0] SettleLast  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                neg_q, neg_d;
    logic [MUL_W-1:0]    mul_a_q, mul_a_d;
    logic [MUL_W-1:0]    mul_b_q, mul_b_d;
    logic [PROD_W-1:0]   prod_q, prod_d;
    logic                timeout_q, timeout_d;

    logic [MUL_W-1:0]    mag_a, mag_b;
    logic [PROD_W-1:0]   prod_raw, prod_neg;

    sign_mag_conv u_conv_a (
        .din     (req_a),
        .sign_en (req_signed),
        .mag     (mag_a)
    );

    sign_mag_conv u_conv_b (
        .din     (req_b),
        .sign_en (req_signed),
        .mag     (mag_b)
    );

    assign prod_raw = {mul_res_high, mul_res_low};
    assign prod_neg = ~prod_raw + PROD_W'(1);

    // Next-state and datapath capture for the IDLE -> ISSUE -> WAIT -> RESP sequence
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        mul_a_d   = mul_a_q;
        mul_b_d   = mul_b_q;
        prod_d    = prod_q;
        timeout_d = timeout_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    mul_a_d = mag_a;
                    mul_b_d = mag_b;
                    neg_d   = req_signed & (req_a[MUL_W-1] ^ req_b[MUL_W-1]);
                    cnt_d   = '0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                // Done is not trusted until the multiplier has seen the new operands
                if (cnt_q == SettleLast) begin
                    cnt_d   = '0;
                    state_d = StWait;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StWait: begin
                if (mul_done) begin
                    prod_d    = neg_q ? prod_neg : prod_raw;
                    timeout_d = 1'b0;
                    state_d   = StResp;
                end else if (cnt_q == TimeoutLast) begin
                    prod_d    = '0;
                    timeout_d = 1'b1;
                    state_d   = StResp;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; operands are deliberately kept across IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            prod_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            mul_a_q   <= mul_a_d;
            mul_b_q   <= mul_b_d;
            prod_q    <= prod_d;
            timeout_q <= timeout_d;
        end
    end

    assign req_ready   = (state_q == StIdle);
    assign rsp_valid   = (state_q == StResp);
    assign busy        = (state_q != StIdle);
    assign rsp_hi      = prod_q[PROD_W-1:MUL_W];
    assign rsp_lo      = prod_q[MUL_W-1:0];
    assign rsp_timeout = timeout_q;
    assign mul_a       = mul_a_q;
    assign mul_b       = mul_b_q;

endmodule
